riscv_irq_ctrl: RTL and testbench
=================================

Name: riscv_irq_ctrl

Overview:
- Machine-level external interrupt controller in front of the core's `hardware_irq` input.
- Gathers N level (optionally edge) sources and gates them with per-source enable, priority and a global threshold.
- Asserts one interrupt line to the CSR/trap unit.
- Software takes an interrupt with a claim/complete handshake over a small word-addressed register port on the data bus.

Parameters:
- N_SRC, 8, number of interrupt sources; legal range 1..8.
- PRIO_W, 3, priority width in bits; priority 0 means never interrupt.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- irq_src  in  N_SRC  raw interrupt sources, active-high
- reg_sel  in  1  register access strobe, one access per asserted cycle
- reg_we  in  1  1 = write, 0 = read; qualified by reg_sel
- reg_addr  in  4  word index
- reg_wdata  in  32  write data
- reg_rdata  out  32  read data, registered
- reg_ready  out  1  one-cycle pulse the cycle after any reg_sel
- hardware_irq  out  1  level to the trap unit's hardware_irq input
- claim_id  out  4  registered best candidate, id+1; 0 = none (debug/perf)

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset state: all registers 0, every gateway in IDLE; hardware_irq=0, claim_id=0, reg_rdata=0, reg_ready=0. Reset mid-claim drops all in-flight state.
- Register map (word index):
  - 0 ENABLE (rw, bits N_SRC-1:0)
  - 1 PENDING (ro)
  - 2 THRESHOLD (rw, bits PRIO_W-1:0)
  - 3 CLAIM (read) / COMPLETE (write)
  - 4 INFLIGHT (ro)
  - 5 EDGE (rw only with the option, else reads 0)
  - 8+k PRIORITY[k] (rw, bits PRIO_W-1:0)
  - Unmapped or out-of-range words read 0; writes to them are ignored. Unused upper bits read 0.
- Register reads: reg_rdata and reg_ready update at the edge after the reg_sel cycle (1-cycle latency). reg_rdata holds its value until the next read.
- Per-source gateway FSM: IDLE -> PENDING -> INFLIGHT -> IDLE.
  - IDLE -> PENDING when irq_src[k]=1 at the clock edge. Enable does not gate the pending latch.
  - PENDING -> INFLIGHT when a CLAIM read returns k+1.
  - INFLIGHT -> IDLE when COMPLETE is written with value k+1.
  - A COMPLETE naming a non-INFLIGHT source is ignored; other writes are unaffected.
  - While INFLIGHT, irq_src[k] is ignored.
  - A source still high after COMPLETE re-enters PENDING one cycle later (IDLE for exactly one cycle).
- Arbitration:
  - Candidate set = PENDING & ENABLE & (PRIORITY>0).
  - Winner = highest PRIORITY; ties go to the lowest index.
  - Computed from the next-state pending vector and registered, so claim_id and hardware_irq change on the same edge as PENDING.
  - No stale cycle after a claim.
- hardware_irq = (winner exists) & (winner priority > THRESHOLD).
  - Latency: irq_src high sampled at edge t gives PENDING and hardware_irq high after edge t.
- CLAIM read:
  - Returns claim_id as sampled in the read cycle (0 if none, or if the winner is not above THRESHOLD).
  - That source moves to INFLIGHT at the same edge.
  - If a new source asserts in the claim cycle, it is latched PENDING normally and competes at the next arbitration.
- COMPLETE write and CLAIM read never occur in the same cycle, because there is one access per reg_sel.
- Register side effects:
  - A write to ENABLE, PRIORITY or THRESHOLD affects arbitration from the following edge.
  - Disabling an INFLIGHT source does not cancel it.

Optional Feature:
- Macro: IRQ_CTRL_EDGE_EN.
- Defined:
  - Word 5 EDGE is rw. EDGE[k]=1 makes source k rising-edge triggered; a registered copy of irq_src detects the edge.
  - A rising edge in IDLE -> PENDING.
  - A rising edge while PENDING is merged into it.
  - A rising edge while INFLIGHT sets a one-deep deferred bit. On COMPLETE, that bit sends the source to PENDING instead of IDLE and clears.
- Undefined:
  - All sources are level-triggered; word 5 reads 0 and writes are ignored.
  - No edge or deferred flops are instantiated.

Test Plan:
- Basic path. Setup: ENABLE=0x01, PRIORITY[0]=3, THRESHOLD=0. Stimulus: irq_src[0] high at cycle 10. Response: hardware_irq=1 after edge 10; CLAIM read returns 1; hardware_irq=0 after the claim edge; INFLIGHT=0x01; COMPLETE write 1 -> INFLIGHT=0.
- Priority and tie-break. Setup: ENABLE=0xFF, PRIORITY[2]=5, PRIORITY[6]=5, PRIORITY[4]=7; sources 2, 4, 6 high. Response: claims return 5, then 3, then 7.
- Threshold and disable. Setup: PRIORITY[1]=2, THRESHOLD=2, source 1 high. Response: hardware_irq=0 and CLAIM returns 0. Then write THRESHOLD=1 -> hardware_irq=1 one edge later. Then write ENABLE=0 -> hardware_irq=0, while PENDING bit 1 stays set.
- Held level. Setup: source 3 held high through claim and complete. Response: PENDING=0 for exactly one cycle after COMPLETE, then 0x08 and hardware_irq=1 again. A COMPLETE with value 2 (source 1, not in flight) leaves INFLIGHT unchanged.
- Reset mid-operation. Setup: rst pulsed while source 0 is INFLIGHT and hardware_irq=1. Response: after the reset edge all registers read 0 and hardware_irq=0; with irq_src still high, source 0 stays IDLE (ENABLE=0) and PENDING rises after the first post-reset edge.
- With IRQ_CTRL_EDGE_EN defined. Setup: EDGE=0x01. Stimulus: pulse source 0 twice while INFLIGHT. Response: one deferred claim after COMPLETE; a second CLAIM after that COMPLETE returns 0.

Source files
------------

// File: rtl/riscv_irq_ctrl.sv
// riscv_irq_ctrl: machine-level external interrupt controller.
// Latches N_SRC sources into per-source gateways (IDLE/PENDING/INFLIGHT),
// arbitrates by priority/enable/threshold and drives hardware_irq.
// Software takes interrupts via a claim/complete handshake on a small
// word-addressed register port.
// Optional feature: define IRQ_CTRL_EDGE_EN to add per-source rising-edge
// triggering (EDGE register, word 5) with a one-deep deferred bit per source.
module riscv_irq_ctrl #(
  parameter int N_SRC  = 8,
  parameter int PRIO_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] irq_src,
  input  logic             reg_sel,
  input  logic             reg_we,
  input  logic [3:0]       reg_addr,
  input  logic [31:0]      reg_wdata,
  output logic [31:0]      reg_rdata,
  output logic             reg_ready,
  output logic             hardware_irq,
  output logic [3:0]       claim_id
);

  // Architectural state; a gateway is IDLE when neither pending nor inflight
  logic [N_SRC-1:0]  enable_r;
  logic [N_SRC-1:0]  pend_r;
  logic [N_SRC-1:0]  infl_r;
  logic [PRIO_W-1:0] thr_r;
  logic [PRIO_W-1:0] prio_r [N_SRC];

  // Next-state values; arbitration looks at these so outputs move with state
  logic [N_SRC-1:0]  enable_nx_s;
  logic [N_SRC-1:0]  pend_nx_s;
  logic [N_SRC-1:0]  infl_nx_s;
  logic [PRIO_W-1:0] thr_nx_s;
  logic [PRIO_W-1:0] prio_nx_s [N_SRC];

  logic              rd_s;
  logic              wr_s;
  logic              claim_rd_s;
  logic              complete_wr_s;
  logic [3:0]        claim_val_s;
  logic [N_SRC-1:0]  trig_s;
  logic [3:0]        win_id_s;
  logic [PRIO_W-1:0] win_prio_s;
  logic              irq_nx_s;
  logic [31:0]       rdata_nx_s;

`ifdef IRQ_CTRL_EDGE_EN
  logic [N_SRC-1:0]  edge_r;
  logic [N_SRC-1:0]  edge_nx_s;
  logic [N_SRC-1:0]  src_q_r;
  logic [N_SRC-1:0]  defer_r;
  logic [N_SRC-1:0]  defer_nx_s;
  logic [N_SRC-1:0]  rise_s;
`endif

  assign rd_s          = reg_sel & ~reg_we;
  assign wr_s          = reg_sel & reg_we;
  assign claim_rd_s    = rd_s & (reg_addr == 4'd3);
  assign complete_wr_s = wr_s & (reg_addr == 4'd3);
  // A claim only hands out the winner when it is actually interrupting
  assign claim_val_s   = hardware_irq ? claim_id : 4'd0;

  // Source trigger: level by default, rising edge where EDGE selects it
  always_comb begin
`ifdef IRQ_CTRL_EDGE_EN
    rise_s = irq_src & ~src_q_r;
    trig_s = (edge_r & rise_s) | (~edge_r & irq_src);
`else
    trig_s = irq_src;
`endif
  end

  // Configuration register write decode
  always_comb begin
    enable_nx_s = enable_r;
    thr_nx_s    = thr_r;
    for (int k = 0; k < N_SRC; k++) begin
      prio_nx_s[k] = prio_r[k];
    end
`ifdef IRQ_CTRL_EDGE_EN
    edge_nx_s = edge_r;
`endif
    if (wr_s) begin
      case (reg_addr)
        4'd0: enable_nx_s = reg_wdata[N_SRC-1:0];
        4'd2: thr_nx_s    = reg_wdata[PRIO_W-1:0];
`ifdef IRQ_CTRL_EDGE_EN
        4'd5: edge_nx_s   = reg_wdata[N_SRC-1:0];
`endif
        default: begin
          for (int k = 0; k < N_SRC; k++) begin
            prio_nx_s[k] = (reg_addr == 4'(8 + k)) ? reg_wdata[PRIO_W-1:0] : prio_nx_s[k];
          end
        end
      endcase
    end else begin
      enable_nx_s = enable_r;
    end
  end

  // Per-source gateway: IDLE -> PENDING -> INFLIGHT -> IDLE
  always_comb begin
    pend_nx_s = pend_r;
    infl_nx_s = infl_r;
`ifdef IRQ_CTRL_EDGE_EN
    defer_nx_s = defer_r;
`endif
    for (int k = 0; k < N_SRC; k++) begin
      if (infl_r[k]) begin
        if (complete_wr_s && (reg_wdata == 32'(k + 1))) begin
          infl_nx_s[k] = 1'b0;
`ifdef IRQ_CTRL_EDGE_EN
          // A deferred edge sends the source straight back to PENDING
          pend_nx_s[k]  = defer_r[k];
          defer_nx_s[k] = 1'b0;
`else
          pend_nx_s[k] = 1'b0;
`endif
        end else begin
`ifdef IRQ_CTRL_EDGE_EN
          defer_nx_s[k] = defer_r[k] | (edge_r[k] & rise_s[k]);
`else
          infl_nx_s[k] = 1'b1;
`endif
        end
      end else if (pend_r[k]) begin
        if (claim_rd_s && (claim_val_s == 4'(k + 1))) begin
          pend_nx_s[k] = 1'b0;
          infl_nx_s[k] = 1'b1;
        end else begin
          pend_nx_s[k] = 1'b1;
        end
      end else begin
        pend_nx_s[k] = trig_s[k];
      end
    end
  end

  // Arbitration: highest priority wins, strict compare keeps lowest index on ties
  always_comb begin
    win_id_s   = 4'd0;
    win_prio_s = '0;
    for (int k = 0; k < N_SRC; k++) begin
      if (pend_nx_s[k] && enable_nx_s[k] && (prio_nx_s[k] > win_prio_s)) begin
        win_id_s   = 4'(k + 1);
        win_prio_s = prio_nx_s[k];
      end else begin
        win_id_s = win_id_s;
      end
    end
    irq_nx_s = (win_id_s != 4'd0) && (win_prio_s > thr_nx_s);
  end

  // Read data mux on the state visible in the access cycle
  always_comb begin
    rdata_nx_s = 32'd0;
    case (reg_addr)
      4'd0: rdata_nx_s = 32'(enable_r);
      4'd1: rdata_nx_s = 32'(pend_r);
      4'd2: rdata_nx_s = 32'(thr_r);
      4'd3: rdata_nx_s = {28'd0, claim_val_s};
      4'd4: rdata_nx_s = 32'(infl_r);
`ifdef IRQ_CTRL_EDGE_EN
      4'd5: rdata_nx_s = 32'(edge_r);
`endif
      default: begin
        for (int k = 0; k < N_SRC; k++) begin
          rdata_nx_s = (reg_addr == 4'(8 + k)) ? 32'(prio_r[k]) : rdata_nx_s;
        end
      end
    endcase
  end

  // State, arbitration result and register port outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      enable_r     <= '0;
      pend_r       <= '0;
      infl_r       <= '0;
      thr_r        <= '0;
      for (int k = 0; k < N_SRC; k++) begin
        prio_r[k] <= '0;
      end
      hardware_irq <= 1'b0;
      claim_id     <= 4'd0;
      reg_rdata    <= 32'd0;
      reg_ready    <= 1'b0;
    end else begin
      enable_r     <= enable_nx_s;
      pend_r       <= pend_nx_s;
      infl_r       <= infl_nx_s;
      thr_r        <= thr_nx_s;
      for (int k = 0; k < N_SRC; k++) begin
        prio_r[k] <= prio_nx_s[k];
      end
      hardware_irq <= irq_nx_s;
      claim_id     <= win_id_s;
      reg_ready    <= reg_sel;
      if (rd_s) begin
        reg_rdata <= rdata_nx_s;
      end
    end
  end

`ifdef IRQ_CTRL_EDGE_EN
  // Edge-detect history, EDGE configuration and deferred-edge bits
  always_ff @(posedge clk) begin
    if (rst) begin
      edge_r  <= '0;
      src_q_r <= '0;
      defer_r <= '0;
    end else begin
      edge_r  <= edge_nx_s;
      src_q_r <= irq_src;
      defer_r <= defer_nx_s;
    end
  end
`endif

endmodule

// File: tb/tb_riscv_irq_ctrl.sv
// Directed self-checking bench for riscv_irq_ctrl (N_SRC=8, PRIO_W=3).
module tb_riscv_irq_ctrl;

  logic        clk;
  logic        rst;
  logic [7:0]  irq_src;
  logic        reg_sel;
  logic        reg_we;
  logic [3:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic [31:0] reg_rdata;
  logic        reg_ready;
  logic        hardware_irq;
  logic [3:0]  claim_id;

  int          n_checks;
  int          n_errors;
  logic [31:0] rd_val;

  riscv_irq_ctrl #(.N_SRC(8), .PRIO_W(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .irq_src      (irq_src),
    .reg_sel      (reg_sel),
    .reg_we       (reg_we),
    .reg_addr     (reg_addr),
    .reg_wdata    (reg_wdata),
    .reg_rdata    (reg_rdata),
    .reg_ready    (reg_ready),
    .hardware_irq (hardware_irq),
    .claim_id     (claim_id)
  );

  // 10 ns core clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one edge and sample 1 ns after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reg_wr(input logic [3:0] a, input logic [31:0] d);
    reg_sel   = 1'b1;
    reg_we    = 1'b1;
    reg_addr  = a;
    reg_wdata = d;
    step();
    reg_sel   = 1'b0;
    reg_we    = 1'b0;
  endtask

  task automatic reg_rd(input logic [3:0] a, output logic [31:0] d);
    reg_sel  = 1'b1;
    reg_we   = 1'b0;
    reg_addr = a;
    step();
    reg_sel  = 1'b0;
    d        = reg_rdata;
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b1;
    irq_src   = 8'h00;
    reg_sel   = 1'b0;
    reg_we    = 1'b0;
    reg_addr  = 4'd0;
    reg_wdata = 32'd0;
    step();
    step();
    rst = 1'b0;

    // Reset state
    check("rst_irq", {31'd0, hardware_irq}, 32'd0);
    check("rst_claim_id", {28'd0, claim_id}, 32'd0);
    check("rst_rdata", reg_rdata, 32'd0);
    check("rst_ready", {31'd0, reg_ready}, 32'd0);

    // Basic path
    reg_wr(4'd0, 32'h01);
    check("ready_pulse", {31'd0, reg_ready}, 32'd1);
    reg_wr(4'd8, 32'd3);
    reg_wr(4'd2, 32'd0);
    step();
    check("ready_drop", {31'd0, reg_ready}, 32'd0);
    check("basic_irq_idle", {31'd0, hardware_irq}, 32'd0);
    irq_src = 8'h01;
    step();
    check("basic_irq_up", {31'd0, hardware_irq}, 32'd1);
    check("basic_claim_id", {28'd0, claim_id}, 32'd1);
    reg_rd(4'd1, rd_val);
    check("basic_pending", rd_val, 32'h01);
    reg_rd(4'd3, rd_val);
    check("basic_claim", rd_val, 32'd1);
    check("basic_irq_after_claim", {31'd0, hardware_irq}, 32'd0);
    irq_src = 8'h00;
    reg_rd(4'd4, rd_val);
    check("basic_inflight", rd_val, 32'h01);
    reg_wr(4'd3, 32'd1);
    reg_rd(4'd4, rd_val);
    check("basic_inflight_done", rd_val, 32'h00);
    reg_rd(4'd8, rd_val);
    check("prio0_readback", rd_val, 32'd3);

    // Priority and tie-break
    reg_wr(4'd0, 32'hFF);
    reg_wr(4'd10, 32'd5);
    reg_wr(4'd14, 32'd5);
    reg_wr(4'd12, 32'd7);
    irq_src = 8'h54;
    step();
    check("tie_claim_id", {28'd0, claim_id}, 32'd5);
    reg_rd(4'd3, rd_val);
    check("tie_claim1", rd_val, 32'd5);
    check("tie_no_stale", {28'd0, claim_id}, 32'd3);
    reg_rd(4'd3, rd_val);
    check("tie_claim2", rd_val, 32'd3);
    reg_rd(4'd3, rd_val);
    check("tie_claim3", rd_val, 32'd7);
    check("tie_irq_low", {31'd0, hardware_irq}, 32'd0);
    reg_rd(4'd4, rd_val);
    check("tie_inflight", rd_val, 32'h54);
    irq_src = 8'h00;
    reg_wr(4'd3, 32'd5);
    reg_wr(4'd3, 32'd3);
    reg_wr(4'd3, 32'd7);
    reg_rd(4'd4, rd_val);
    check("tie_inflight_done", rd_val, 32'h00);

    // Threshold and disable
    reg_wr(4'd9, 32'd2);
    reg_wr(4'd2, 32'd2);
    irq_src = 8'h02;
    step();
    irq_src = 8'h00;
    check("thr_irq_blocked", {31'd0, hardware_irq}, 32'd0);
    check("thr_claim_id", {28'd0, claim_id}, 32'd2);
    reg_rd(4'd3, rd_val);
    check("thr_claim_zero", rd_val, 32'd0);
    reg_wr(4'd2, 32'd1);
    check("thr_irq_lowered", {31'd0, hardware_irq}, 32'd1);
    reg_wr(4'd0, 32'h00);
    check("dis_irq", {31'd0, hardware_irq}, 32'd0);
    reg_rd(4'd1, rd_val);
    check("dis_pending_kept", rd_val, 32'h02);
    reg_wr(4'd0, 32'h02);
    reg_rd(4'd3, rd_val);
    check("thr_claim_src1", rd_val, 32'd2);
    reg_wr(4'd3, 32'd2);
    reg_wr(4'd2, 32'd0);

    // Held level
    reg_wr(4'd0, 32'h08);
    reg_wr(4'd11, 32'd4);
    irq_src = 8'h08;
    step();
    check("held_irq", {31'd0, hardware_irq}, 32'd1);
    reg_rd(4'd3, rd_val);
    check("held_claim", rd_val, 32'd4);
    check("held_irq_inflight", {31'd0, hardware_irq}, 32'd0);
    reg_wr(4'd3, 32'd2);
    reg_rd(4'd4, rd_val);
    check("bogus_complete", rd_val, 32'h08);
    reg_wr(4'd3, 32'd4);
    check("held_irq_gap", {31'd0, hardware_irq}, 32'd0);
    reg_rd(4'd1, rd_val);
    check("held_pending_gap", rd_val, 32'h00);
    check("held_irq_back", {31'd0, hardware_irq}, 32'd1);
    reg_rd(4'd1, rd_val);
    check("held_pending_back", rd_val, 32'h08);

    // Reset mid-operation
    reg_wr(4'd0, 32'h01);
    irq_src = 8'h09;
    step();
    reg_rd(4'd3, rd_val);
    check("rst_pre_claim", rd_val, 32'd1);
    reg_wr(4'd0, 32'h09);
    check("rst_pre_irq", {31'd0, hardware_irq}, 32'd1);
    reg_rd(4'd4, rd_val);
    check("rst_pre_inflight", rd_val, 32'h01);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_irq", {31'd0, hardware_irq}, 32'd0);
    check("mid_rst_rdata", reg_rdata, 32'd0);
    reg_rd(4'd0, rd_val);
    check("mid_rst_enable", rd_val, 32'h00);
    reg_rd(4'd1, rd_val);
    check("mid_rst_pending", rd_val, 32'h09);
    reg_rd(4'd4, rd_val);
    check("mid_rst_inflight", rd_val, 32'h00);
    reg_rd(4'd8, rd_val);
    check("mid_rst_prio0", rd_val, 32'd0);
    check("mid_rst_irq_stays", {31'd0, hardware_irq}, 32'd0);
    check("mid_rst_claim_id", {28'd0, claim_id}, 32'd0);

    // Unmapped words and EDGE word
    reg_wr(4'd7, 32'hFFFF_FFFF);
    reg_rd(4'd7, rd_val);
    check("unmapped_rd", rd_val, 32'd0);
    reg_wr(4'd2, 32'hFFFF_FFFF);
    reg_rd(4'd2, rd_val);
    check("thr_upper_bits", rd_val, 32'd7);
    reg_wr(4'd5, 32'h01);
    reg_rd(4'd5, rd_val);
`ifdef IRQ_CTRL_EDGE_EN
    check("edge_word", rd_val, 32'h01);
`else
    check("edge_word", rd_val, 32'h00);
`endif

`ifdef IRQ_CTRL_EDGE_EN
    // Edge-triggered source with deferred re-trigger
    irq_src = 8'h00;
    rst = 1'b1;
    step();
    rst = 1'b0;
    reg_wr(4'd0, 32'h01);
    reg_wr(4'd8, 32'd3);
    reg_wr(4'd5, 32'h01);
    irq_src = 8'h01;
    step();
    irq_src = 8'h00;
    check("edge_irq", {31'd0, hardware_irq}, 32'd1);
    reg_rd(4'd3, rd_val);
    check("edge_claim1", rd_val, 32'd1);
    irq_src = 8'h01;
    step();
    irq_src = 8'h00;
    step();
    irq_src = 8'h01;
    step();
    irq_src = 8'h00;
    step();
    check("edge_irq_inflight", {31'd0, hardware_irq}, 32'd0);
    reg_wr(4'd3, 32'd1);
    check("edge_deferred_irq", {31'd0, hardware_irq}, 32'd1);
    reg_rd(4'd3, rd_val);
    check("edge_claim2", rd_val, 32'd1);
    reg_wr(4'd3, 32'd1);
    reg_rd(4'd3, rd_val);
    check("edge_claim3", rd_val, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
